// File: rtl/psk_modulator_param.sv
// Parametrised M-PSK modulator: serial bits -> symbols -> phase-mapped
// offset-binary sine samples, one sample per sample_en strobe.
module psk_modulator_param #(
  parameter int BITS_PER_SYM    = 2,
  parameter int LUT_N           = 32,
  parameter int SAMPLES_PER_SYM = 32,
  parameter int CYC_PER_SYM     = 1,
  parameter int OUT_W           = 8,
  parameter int GRAY            = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [OUT_W-1:0] wav_out,
  output logic             wav_valid,
  output logic             sym_start,
  output logic             busy
);

  localparam int IW = $clog2(LUT_N);
  localparam int CW = $clog2(BITS_PER_SYM + 1);
  localparam int NW = $clog2(SAMPLES_PER_SYM + 1);
  localparam logic [CW-1:0]    BPS_C  = CW'(BITS_PER_SYM);
  localparam logic [NW-1:0]    SPS_C  = NW'(SAMPLES_PER_SYM);
  localparam logic [IW-1:0]    STEP_I = IW'(LUT_N * CYC_PER_SYM / SAMPLES_PER_SYM);
  localparam logic [OUT_W-1:0] MID    = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           bit_cnt;
  logic [BITS_PER_SYM-1:0] asm_r;
  logic [BITS_PER_SYM:0]   asm_sh;
  logic [BITS_PER_SYM-1:0] hold;
  logic                    hold_full;
  logic [NW-1:0]           smp_n;
  logic [IW-1:0]           ph;
  logic [IW-1:0]           load_base;
  logic                    xfer;
  logic                    load;
  logic                    adv;
  logic [OUT_W-1:0]        lut [LUT_N];

  // Offset-binary sine entry, rounded half away from zero.
  function automatic logic [OUT_W-1:0] lut_val(input int k);
    real amp;
    real s;
    int  r;
    amp = real'((1 << (OUT_W - 1)) - 1);
    s   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N));
    if (s >= 0.0) r = int'($floor(s + 0.5));
    else          r = -int'($floor(-s + 0.5));
    return OUT_W'(r + (1 << (OUT_W - 1)));
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [BITS_PER_SYM-1:0] gray2bin(input logic [BITS_PER_SYM-1:0] g);
    logic [BITS_PER_SYM-1:0] b;
    b = g;
    for (int unsigned i = 1; i < BITS_PER_SYM; i++) b = b ^ (g >> i);
    return b;
  endfunction

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut[k] = lut_val(k);
  end

  assign asm_sh    = {asm_r, bit_in};
  assign bit_ready = (bit_cnt < BPS_C);
  assign xfer      = bit_valid && bit_ready;
  assign busy      = (state == RUN);
  // Phase p occupies the top BITS_PER_SYM bits of the table index.
  assign load_base = IW'((GRAY != 0) ? gray2bin(hold) : hold) << (IW - BITS_PER_SYM);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and per-strobe action: load a held symbol, advance, or stop
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    if (sample_en) begin
      unique case (state)
        IDLE: if (hold_full) begin
          load     = 1'b1;
          state_nx = RUN;
        end
        RUN: begin
          if (smp_n < SPS_C)  adv      = 1'b1;
          else if (hold_full) load     = 1'b1;
          else                state_nx = IDLE;
        end
      endcase
    end
  end

  // Bit assembler and one-deep hold register; a load consumes the hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt   <= '0;
      asm_r     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (xfer) begin
        asm_r   <= asm_sh[BITS_PER_SYM-1:0];
        bit_cnt <= bit_cnt + 1'b1;
      end else if (bit_cnt == BPS_C && !hold_full) begin
        hold      <= asm_r;
        hold_full <= 1'b1;
        bit_cnt   <= '0;
      end
      if (load) hold_full <= 1'b0;
    end
  end

  // Sample generation; ph accumulates base + n*STEP instead of multiplying
  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_n     <= '0;
      ph        <= '0;
      wav_out   <= MID;
      wav_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      wav_valid <= sample_en;
      sym_start <= load;
      if (load) begin
        wav_out <= lut[load_base];
        ph      <= load_base + STEP_I;
        smp_n   <= NW'(1);
      end else if (adv) begin
        wav_out <= lut[ph];
        ph      <= ph + STEP_I;
        smp_n   <= smp_n + 1'b1;
      end else if (sample_en) begin
        wav_out <= MID;
      end
    end
  end

endmodule

// File: tb/tb_psk_modulator_param.sv
// Directed bench for psk_modulator_param across four parameter sets.
module tb_psk_modulator_param;

  logic       clk;
  logic       rst;
  logic       se [4];
  logic       bi [4];
  logic       bv [4];
  logic       br [4];
  logic       wv [4];
  logic       ss [4];
  logic       bz [4];
  logic [7:0] wo [4];

  int checks   = 0;
  int failures = 0;

  // Hand-computed round(127*sin(2*pi*k/32)) + 128
  logic [7:0] lut_ref [32] = '{
    8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
    8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
    8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
    8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103};

  // d0: QPSK Gray defaults
  psk_modulator_param u_d0 (
    .clk(clk), .rst(rst), .sample_en(se[0]), .bit_in(bi[0]), .bit_valid(bv[0]),
    .bit_ready(br[0]), .wav_out(wo[0]), .wav_valid(wv[0]), .sym_start(ss[0]), .busy(bz[0]));

  // d1: BPSK
  psk_modulator_param #(.BITS_PER_SYM(1)) u_d1 (
    .clk(clk), .rst(rst), .sample_en(se[1]), .bit_in(bi[1]), .bit_valid(bv[1]),
    .bit_ready(br[1]), .wav_out(wo[1]), .wav_valid(wv[1]), .sym_start(ss[1]), .busy(bz[1]));

  // d2: 8PSK natural binary
  psk_modulator_param #(.BITS_PER_SYM(3), .GRAY(0)) u_d2 (
    .clk(clk), .rst(rst), .sample_en(se[2]), .bit_in(bi[2]), .bit_valid(bv[2]),
    .bit_ready(br[2]), .wav_out(wo[2]), .wav_valid(wv[2]), .sym_start(ss[2]), .busy(bz[2]));

  // d3: QPSK, two carrier periods over 16 samples
  psk_modulator_param #(.SAMPLES_PER_SYM(16), .CYC_PER_SYM(2)) u_d3 (
    .clk(clk), .rst(rst), .sample_en(se[3]), .bit_in(bi[3]), .bit_valid(bv[3]),
    .bit_ready(br[3]), .wav_out(wo[3]), .wav_valid(wv[3]), .sym_start(ss[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      se[i] = 1'b0;
      bi[i] = 1'b0;
      bv[i] = 1'b0;
    end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send_bit(input int d, input logic b);
    logic acc;
    int   guard;
    bv[d] = 1'b1;
    bi[d] = b;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      acc = br[d];
      tick();
      guard++;
    end
    bv[d] = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic strobe(input int d);
    se[d] = 1'b1;
    tick();
    se[d] = 1'b0;
  endtask

  typedef struct {
    int         dut;
    int         nbits;
    logic [2:0] bits;
    logic [7:0] first;
    logic [7:0] second;
  } vec_t;

  vec_t vt [11];

  initial begin
    logic [5:0] bp_bits;
    logic       bp_exp [8];
    logic       acc;
    int         k;
    int         ss_cnt;

    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      se[i] = 1'b0;
      bi[i] = 1'b0;
      bv[i] = 1'b0;
    end

    vt[0]  = '{0, 2, 3'b000, 8'd128, 8'd153};
    vt[1]  = '{0, 2, 3'b001, 8'd255, 8'd253};
    vt[2]  = '{0, 2, 3'b011, 8'd128, 8'd103};
    vt[3]  = '{0, 2, 3'b010, 8'd1,   8'd3};
    vt[4]  = '{1, 1, 3'b001, 8'd128, 8'd103};
    vt[5]  = '{1, 1, 3'b000, 8'd128, 8'd153};
    vt[6]  = '{2, 3, 3'b010, 8'd255, 8'd253};
    vt[7]  = '{2, 3, 3'b111, 8'd38,  8'd57};
    vt[8]  = '{2, 3, 3'b100, 8'd128, 8'd103};
    vt[9]  = '{3, 2, 3'b000, 8'd128, 8'd218};
    vt[10] = '{3, 2, 3'b010, 8'd1,   8'd38};

    // Reset state, then strobes with nothing to send
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      check("rst_wav", wo[d], 8'd128);
      check("rst_busy", bz[d], 1'b0);
      check("rst_ready", br[d], 1'b1);
      check("rst_valid", wv[d], 1'b0);
      check("rst_sym_start", ss[d], 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(0);
      check("idle_wav", wo[0], 8'd128);
      check("idle_valid", wv[0], 1'b1);
      check("idle_busy", bz[0], 1'b0);
      check("idle_sym_start", ss[0], 1'b0);
      tick();
      check("idle_valid_drop", wv[0], 1'b0);
    end

    // Table: first two samples of one symbol per configuration
    for (int v = 0; v < 11; v++) begin
      do_reset();
      for (int b = vt[v].nbits - 1; b >= 0; b--) send_bit(vt[v].dut, vt[v].bits[b]);
      tick();
      strobe(vt[v].dut);
      check("vec_first", wo[vt[v].dut], vt[v].first);
      check("vec_sym_start", ss[vt[v].dut], 1'b1);
      check("vec_valid", wv[vt[v].dut], 1'b1);
      check("vec_busy", bz[vt[v].dut], 1'b1);
      tick();
      check("vec_hold_between", wo[vt[v].dut], vt[v].first);
      check("vec_valid_drop", wv[vt[v].dut], 1'b0);
      strobe(vt[v].dut);
      check("vec_second", wo[vt[v].dut], vt[v].second);
      check("vec_sym_start_drop", ss[vt[v].dut], 1'b0);
    end

    // Input latency: strobe one cycle after the last bit is too early
    do_reset();
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    se[0] = 1'b1;
    tick();
    check("lat_early_wav", wo[0], 8'd128);
    check("lat_early_busy", bz[0], 1'b0);
    check("lat_early_sym_start", ss[0], 1'b0);
    tick();
    se[0] = 1'b0;
    check("lat_first_wav", wo[0], 8'd255);
    check("lat_first_sym_start", ss[0], 1'b1);

    // Two QPSK symbols back to back, strobe every 4 cycles
    do_reset();
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    tick();
    ss_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      strobe(0);
      if (ss[0]) ss_cnt++;
      if (i < 32) check("qpsk_sym1", wo[0], lut_ref[(8 + i) % 32]);
      else        check("qpsk_sym2", wo[0], lut_ref[(24 + i) % 32]);
      check("qpsk_sym_start", ss[0], (i == 0 || i == 32) ? 1'b1 : 1'b0);
      check("qpsk_busy", bz[0], 1'b1);
      tick();
      tick();
      tick();
    end
    check("qpsk_sym_start_count", ss_cnt, 2);
    strobe(0);
    check("qpsk_end_wav", wo[0], 8'd128);
    check("qpsk_end_busy", bz[0], 1'b0);

    // Back-pressure with bit_valid held high and no strobes
    do_reset();
    bp_bits = 6'b101100;
    bp_exp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    k = 0;
    bv[0] = 1'b1;
    bi[0] = bp_bits[5];
    for (int c = 0; c < 8; c++) begin
      check("bp_ready", br[0], bp_exp[c]);
      acc = br[0];
      tick();
      if (acc) begin
        k++;
        if (k < 6) bi[0] = bp_bits[5 - k];
      end
    end
    check("bp_accepted", k, 4);
    se[0] = 1'b1;
    check("bp_ready_at_strobe", br[0], 1'b0);
    tick();
    se[0] = 1'b0;
    check("bp_first_wav", wo[0], 8'd1);
    check("bp_ready_after_consume", br[0], 1'b0);
    tick();
    check("bp_ready_reassert", br[0], 1'b1);
    for (int c = 0; c < 2; c++) begin
      acc = br[0];
      tick();
      if (acc) begin
        k++;
        if (k < 6) bi[0] = bp_bits[5 - k];
      end
    end
    bv[0] = 1'b0;
    check("bp_accepted_total", k, 6);

    // Two carrier periods in 16 samples, symbol 00
    do_reset();
    send_bit(3, 1'b0);
    send_bit(3, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      strobe(3);
      check("mc_wav", wo[3], lut_ref[(4 * i) % 32]);
      check("mc_sym_start", ss[3], (i == 0) ? 1'b1 : 1'b0);
      tick();
    end
    strobe(3);
    check("mc_end_wav", wo[3], 8'd128);
    check("mc_end_busy", bz[3], 1'b0);

    // Reset at sample 10 with the next symbol held
    do_reset();
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    tick();
    strobe(0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    tick();
    for (int i = 1; i < 10; i++) begin
      strobe(0);
      tick();
    end
    check("mr_pre_wav", wo[0], lut_ref[17]);
    check("mr_pre_busy", bz[0], 1'b1);
    rst   = 1'b0;
    se[0] = 1'b1;
    tick();
    rst   = 1'b1;
    se[0] = 1'b0;
    check("mr_wav", wo[0], 8'd128);
    check("mr_busy", bz[0], 1'b0);
    check("mr_ready", br[0], 1'b1);
    check("mr_valid", wv[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      strobe(0);
      check("mr_after_wav", wo[0], 8'd128);
      check("mr_after_busy", bz[0], 1'b0);
      check("mr_after_sym_start", ss[0], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
